pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It combines the load-use stall from the hazard detector, taken-branch flushes and I/D-cache misses into per-stage write-enable and flush controls. It arbitrates the single shared memory port between I-cache and D-cache line fills, and counts fill beats. It also handles the halt condition and keeps a stall-cycle performance counter.

Parameters:
FILL_BEATS, 8, memory beats per cache-line fill (power of 2, >=2)
CNT_W, 3, beat counter width, log2(FILL_BEATS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
haz_stall  in  1  load-use stall from hazard detector
branch_taken  in  1  branch/jump resolved taken in ID
icache_miss  in  1  I-cache miss on current fetch
dcache_miss  in  1  D-cache miss on current X/M access
mem_valid  in  1  shared memory returns one beat this cycle
halt_mw  in  1  HLT instruction in M/W register
mem_req  out  1  shared memory request, high for whole fill
mem_sel  out  1  0 = I-cache owns port, 1 = D-cache
icache_fill_we  out  1  write beat into I-cache
dcache_fill_we  out  1  write beat into D-cache
fill_beat  out  CNT_W  word index of current beat
fill_done  out  1  last beat of a fill accepted this cycle
pc_we, fd_we, dx_we, xm_we, mw_we  out  1 each  stage register enables
fd_flush, dx_flush  out  1 each  load NOP into F/D or D/X
halted  out  1  core halted (sticky)
stall_cnt  out  16  cycles with pc_we=0 while not halted, saturating

Behaviour:
- FSM states: IDLE, IFILL, DFILL, HALTED. The state, fill_beat, mem_req, mem_sel, halted and stall_cnt are registered. All enables, flushes and fill strobes are combinational from state and inputs.
- Reset (rst_n=0 at a clk edge): state=IDLE, fill_beat=0, mem_req=0, mem_sel=0, halted=0, stall_cnt=0. This applies mid-fill too: the fill is abandoned and no fill_done is issued.
- IDLE transitions, first match wins:
  - halt_mw -> HALTED.
  - dcache_miss -> DFILL, with mem_sel=1.
  - icache_miss -> IFILL, with mem_sel=0.
  - mem_req rises on the same edge.
- D-cache has priority because it is the older instruction. If both misses are present, DFILL runs first. IFILL is then taken from IDLE after at least one IDLE cycle.
- In IFILL/DFILL, each cycle with mem_valid=1:
  - The matching *_fill_we is asserted and fill_beat increments, wrapping to 0.
  - When fill_beat==FILL_BEATS-1 and mem_valid=1: fill_done=1 the same cycle, next state=IDLE, mem_req falls.
  - mem_valid is ignored in IDLE and HALTED; no fill_we is asserted there.
- Stage-control priority, highest first:
  1. HALTED: all *_we=0, no flushes, halted=1.
  2. Memory freeze (state=DFILL, or IDLE with dcache_miss): all *_we=0, no flushes.
  3. Load-use (haz_stall): pc_we=fd_we=0, dx_flush=1; dx/xm/mw_we=1.
  4. Branch (branch_taken): all *_we=1, fd_flush=1.
  5. I-miss (state=IFILL, or IDLE with icache_miss): pc_we=fd_we=0, fd_flush=1; later stages run and drain.
  6. Otherwise: all *_we=1, no flushes.
- A branch during IFILL is held: the I-miss freeze wins, and ID keeps the branch because F/D is frozen.
- halt_mw during a fill: the fill completes and returns to IDLE, then HALTED is entered the next cycle. HALTED is left only by reset.
- stall_cnt increments on each edge where pc_we=0 and state!=HALTED, and saturates at 0xFFFF.

Test Plan:
- Reset mid-DFILL at beat 5 -> next cycle state IDLE, mem_req=0, fill_beat=0, no fill_done, stall_cnt=0.
- icache_miss held, FILL_BEATS=8, mem_valid every other cycle -> mem_req=1/mem_sel=0 from cycle 1, 8 icache_fill_we pulses with fill_beat 0..7, fill_done on the 8th beat, pc_we=0 and fd_flush=1 throughout, stall_cnt=16.
- dcache_miss and icache_miss asserted together -> DFILL first (mem_sel=1, all *_we=0 for 8 beats), one IDLE cycle, then IFILL (mem_sel=0).
- haz_stall and branch_taken together in IDLE, no misses -> pc_we=0, fd_we=0, dx_flush=1, fd_flush=0; next cycle branch alone gives fd_flush=1, pc_we=1.
- halt_mw rises during DFILL beat 3 -> fill completes (fill_done at beat 7), IDLE for one cycle, then halted=1 and all *_we=0 permanently; stall_cnt frozen.
- Force 70000 cycles of haz_stall -> stall_cnt saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage core.
// Merges load-use stalls, branch flushes and cache misses into per-stage
// enables/flushes, owns the shared memory port during line fills, handles
// halt, and keeps a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int FILL_BEATS = 8,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             haz_stall,
  input  logic             branch_taken,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             mem_valid,
  input  logic             halt_mw,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             icache_fill_we,
  output logic             dcache_fill_we,
  output logic [CNT_W-1:0] fill_beat,
  output logic             fill_done,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             xm_we,
  output logic             mw_we,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, HALTED} state_t;

  state_t state, stateNxt;
  logic   inFill;
  logic   beatAcc;
  logic   lastBeat;
  logic   dFreeze;
  logic   iMissIdle;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fill strobes, next state and stage controls, all from state and inputs.
  always_comb begin
    stateNxt       = state;
    inFill         = (state == IFILL) || (state == DFILL);
    beatAcc        = inFill && mem_valid;
    lastBeat       = (fill_beat == CNT_W'(FILL_BEATS - 1));
    fill_done      = beatAcc && lastBeat;
    icache_fill_we = (state == IFILL) && mem_valid;
    dcache_fill_we = (state == DFILL) && mem_valid;
    dFreeze        = (state == DFILL) || ((state == IDLE) && dcache_miss);
    iMissIdle      = (state == IDLE) && icache_miss;
    pc_we          = 1'b1;
    fd_we          = 1'b1;
    dx_we          = 1'b1;
    xm_we          = 1'b1;
    mw_we          = 1'b1;
    fd_flush       = 1'b0;
    dx_flush       = 1'b0;

    case (state)
      IDLE: begin
        if (halt_mw)          stateNxt = HALTED;
        else if (dcache_miss) stateNxt = DFILL;
        else if (icache_miss) stateNxt = IFILL;
      end
      IFILL, DFILL: begin
        if (fill_done) stateNxt = IDLE;
      end
      default: stateNxt = HALTED;
    endcase

    // The D-side freeze stops everything because the stalled access sits in X/M.
    // An ongoing I-fill outranks a branch: F/D is frozen, so ID keeps the branch
    // and resolves it again once the fetch completes.
    if ((state == HALTED) || dFreeze) begin
      pc_we = 1'b0;
      fd_we = 1'b0;
      dx_we = 1'b0;
      xm_we = 1'b0;
      mw_we = 1'b0;
    end else if (haz_stall) begin
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      dx_flush = 1'b1;
    end else if (state == IFILL) begin
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      fd_flush = 1'b1;
    end else if (branch_taken) begin
      fd_flush = 1'b1;
    end else if (iMissIdle) begin
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      fd_flush = 1'b1;
    end
  end

  // State, fill bookkeeping, halt flag and stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_beat <= '0;
      mem_req   <= 1'b0;
      mem_sel   <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= stateNxt;
      halted <= (stateNxt == HALTED);
      if (beatAcc) fill_beat <= fill_beat + CNT_W'(1);
      if ((state == IDLE) && ((stateNxt == IFILL) || (stateNxt == DFILL))) begin
        mem_req <= 1'b1;
        mem_sel <= (stateNxt == DFILL);
      end else if (fill_done) begin
        mem_req <= 1'b0;
      end
      if ((state != HALTED) && !pc_we) stall_cnt <= satInc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table for stage control in IDLE plus
// hand-written sequences for fills, halt, reset and counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       haz_stall, branch_taken, icache_miss, dcache_miss, mem_valid, halt_mw;
  logic       mem_req, mem_sel, icache_fill_we, dcache_fill_we, fill_done;
  logic [2:0] fill_beat;
  logic       pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, halted;
  logic [15:0] stall_cnt;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FILL_BEATS(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .haz_stall(haz_stall), .branch_taken(branch_taken),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .mem_valid(mem_valid), .halt_mw(halt_mw),
    .mem_req(mem_req), .mem_sel(mem_sel),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .fill_beat(fill_beat), .fill_done(fill_done),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
    .fd_flush(fd_flush), .dx_flush(dx_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       haz, br, im, dm, mv;
    logic [4:0] we;   // {pc, fd, dx, xm, mw}
    logic       fdf, dxf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    haz_stall = 0; branch_taken = 0; icache_miss = 0;
    dcache_miss = 0; mem_valid = 0; halt_mw = 0;
  endtask

  task automatic doReset();
    clearIn();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  function automatic int weBus();
    return int'({pc_we, fd_we, dx_we, xm_we, mw_we});
  endfunction

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 5'b11111, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 5'b00111, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 0, 5'b11111, 1, 0};
    vecs[3] = '{1, 1, 0, 0, 0, 5'b00111, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 0, 5'b00111, 1, 0};
    vecs[5] = '{0, 0, 0, 1, 0, 5'b00000, 0, 0};
    vecs[6] = '{0, 0, 1, 1, 1, 5'b00000, 0, 0};
    vecs[7] = '{1, 0, 0, 1, 0, 5'b00000, 0, 0};
    vecs[8] = '{1, 0, 1, 0, 0, 5'b00111, 0, 1};
    vecs[9] = '{0, 0, 0, 0, 1, 5'b11111, 0, 0};

    clearIn();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;

    // Reset state
    check("rst mem_req", mem_req, 0);
    check("rst mem_sel", mem_sel, 0);
    check("rst fill_beat", fill_beat, 0);
    check("rst halted", halted, 0);
    check("rst stall_cnt", stall_cnt, 0);
    check("rst fill_done", fill_done, 0);

    // Stage-control table, evaluated in IDLE
    for (int i = 0; i < 10; i++) begin
      haz_stall = vecs[i].haz; branch_taken = vecs[i].br;
      icache_miss = vecs[i].im; dcache_miss = vecs[i].dm; mem_valid = vecs[i].mv;
      #1;
      check($sformatf("vec%0d we", i), weBus(), int'(vecs[i].we));
      check($sformatf("vec%0d fd_flush", i), fd_flush, vecs[i].fdf);
      check($sformatf("vec%0d dx_flush", i), dx_flush, vecs[i].dxf);
      check($sformatf("vec%0d fill_we", i), int'({icache_fill_we, dcache_fill_we}), 0);
      doReset();
    end

    // I-cache fill, mem_valid every other cycle, branch held mid-fill
    doReset();
    icache_miss = 1;
    #1;
    check("ifill idle pc_we", pc_we, 0);
    check("ifill idle fd_flush", fd_flush, 1);
    tick();
    check("ifill mem_req", mem_req, 1);
    check("ifill mem_sel", mem_sel, 0);
    icache_miss = 0;
    begin
      int beat = 0;
      for (int k = 0; k < 15; k++) begin
        mem_valid = ((k % 2) == 0);
        branch_taken = (k == 3);
        #1;
        check($sformatf("ifill c%0d pc_we", k), pc_we, 0);
        check($sformatf("ifill c%0d fd_flush", k), fd_flush, 1);
        check($sformatf("ifill c%0d ic_we", k), icache_fill_we, mem_valid);
        check($sformatf("ifill c%0d dc_we", k), dcache_fill_we, 0);
        if (mem_valid) begin
          check($sformatf("ifill beat%0d idx", beat), fill_beat, beat);
          check($sformatf("ifill beat%0d done", beat), fill_done, (beat == 7));
          beat++;
        end
        tick();
      end
    end
    clearIn();
    #1;
    check("ifill end mem_req", mem_req, 0);
    check("ifill end fill_beat", fill_beat, 0);
    check("ifill stall_cnt", stall_cnt, 16);

    // Both misses: D-fill first, one IDLE cycle, then I-fill
    doReset();
    dcache_miss = 1; icache_miss = 1;
    #1;
    check("both idle we", weBus(), 0);
    tick();
    check("both dfill mem_sel", mem_sel, 1);
    check("both dfill mem_req", mem_req, 1);
    for (int b = 0; b < 8; b++) begin
      mem_valid = 1;
      if (b == 7) dcache_miss = 0;
      #1;
      check($sformatf("both d%0d we", b), weBus(), 0);
      check($sformatf("both d%0d dc_we", b), dcache_fill_we, 1);
      check($sformatf("both d%0d ic_we", b), icache_fill_we, 0);
      check($sformatf("both d%0d idx", b), fill_beat, b);
      check($sformatf("both d%0d done", b), fill_done, (b == 7));
      tick();
    end
    mem_valid = 0;
    #1;
    check("both gap mem_req", mem_req, 0);
    check("both gap pc_we", pc_we, 0);
    check("both gap fd_flush", fd_flush, 1);
    check("both gap dx_we", dx_we, 1);
    tick();
    check("both ifill mem_req", mem_req, 1);
    check("both ifill mem_sel", mem_sel, 0);

    // Load-use and branch together, then branch alone
    doReset();
    haz_stall = 1; branch_taken = 1;
    #1;
    check("hb pc_we", pc_we, 0);
    check("hb fd_we", fd_we, 0);
    check("hb dx_flush", dx_flush, 1);
    check("hb fd_flush", fd_flush, 0);
    tick();
    haz_stall = 0;
    #1;
    check("br fd_flush", fd_flush, 1);
    check("br pc_we", pc_we, 1);
    check("br dx_flush", dx_flush, 0);

    // Halt raised at D-fill beat 3
    doReset();
    dcache_miss = 1;
    tick();
    for (int b = 0; b < 8; b++) begin
      mem_valid = 1;
      halt_mw = (b >= 3);
      if (b == 7) dcache_miss = 0;
      #1;
      check($sformatf("halt d%0d done", b), fill_done, (b == 7));
      tick();
    end
    mem_valid = 0;
    #1;
    check("halt idle halted", halted, 0);
    check("halt idle mem_req", mem_req, 0);
    check("halt idle pc_we", pc_we, 1);
    tick();
    check("halt halted", halted, 1);
    check("halt we", weBus(), 0);
    check("halt stall_cnt", stall_cnt, 9);
    halt_mw = 0; haz_stall = 1; dcache_miss = 1; mem_valid = 1; branch_taken = 1;
    repeat (5) tick();
    check("halt sticky", halted, 1);
    check("halt sticky we", weBus(), 0);
    check("halt flushes", int'({fd_flush, dx_flush}), 0);
    check("halt stall frozen", stall_cnt, 9);
    check("halt mem_req", mem_req, 0);
    check("halt dc_we", dcache_fill_we, 0);

    // Reset in the middle of a D-fill at beat 5
    doReset();
    dcache_miss = 1;
    tick();
    mem_valid = 1;
    repeat (5) tick();
    check("midrst beat", fill_beat, 5);
    rst_n = 0;
    #1;
    check("midrst done", fill_done, 0);
    tick();
    rst_n = 1;
    clearIn();
    #1;
    check("midrst mem_req", mem_req, 0);
    check("midrst fill_beat", fill_beat, 0);
    check("midrst mem_sel", mem_sel, 0);
    check("midrst stall_cnt", stall_cnt, 0);
    check("midrst fill_done", fill_done, 0);

    // Stall counter saturation
    doReset();
    haz_stall = 1;
    repeat (65534) tick();
    check("sat pre", stall_cnt, 16'hFFFE);
    repeat (4466) tick();
    check("sat hold", stall_cnt, 16'hFFFF);
    clearIn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
